// File: rtl/segment_driver.sv
// ---------------------------------------------------------------------------
// segment_driver
//
// Time-multiplexed driver for a four-digit, common-anode seven-segment
// display. It scans one digit at a time, and each digit stays enabled for
// REFRESH_COUNT clocks. The selected nibble is decoded to a hex glyph.
//
// Parameters
//   REFRESH_COUNT  clocks per digit dwell (2 .. 2**20)
//
// Ports
//   clk100Mhz      in   system clock; all state changes on the rising edge
//   rst            in   asynchronous, active-low reset
//   display_value  in   [15:12] digit 3 (leftmost) .. [3:0] digit 0 (rightmost)
//   display_dp     in   1 = light the decimal point on digit 2
//   cathodes       out  [7:1] = g f e d c b a, active-low
//   anodes         out  [3:0] digit enables, active-low, one-hot-zero
//   dp             out  decimal-point segment, active-low
//
// All outputs come from one register stage, so the anode and the glyph
// always belong to the same digit. There is no combinational path from an
// input to an output.
// ---------------------------------------------------------------------------
module segment_driver #(
    parameter int unsigned REFRESH_COUNT = 2500
) (
    input  logic        clk100Mhz,
    input  logic        rst,
    input  logic [15:0] display_value,
    input  logic        display_dp,
    output logic [7:1]  cathodes,
    output logic [3:0]  anodes,
    output logic        dp
);

    localparam int unsigned CNT_W = (REFRESH_COUNT > 2) ? $clog2(REFRESH_COUNT) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(REFRESH_COUNT - 1);

    logic [CNT_W-1:0] count_reg, count_next;
    logic [1:0]       digit_reg, digit_next;
    logic [3:0]       nibble;
    logic [6:0]       seg_next;
    logic [3:0]       anodes_next;
    logic             dp_next;
    logic [6:0]       cathodes_reg;
    logic [3:0]       anodes_reg;
    logic             dp_reg;

    // Dwell counter. At its wrap it advances the digit index.
    always_comb begin
        count_next = count_reg + CNT_W'(1);
        digit_next = digit_reg;
        if (count_reg == TERMINAL) begin
            count_next = '0;
            digit_next = digit_reg + 2'd1;
        end
    end

    // The outputs are decoded from the current index, not the next one.
    // The first edge after reset therefore shows digit 0. Every digit,
    // including the first after reset, is then shown for exactly
    // REFRESH_COUNT edges.
    always_comb begin
        nibble = 4'h0;
        case (digit_reg)
            2'd0: nibble = display_value[3:0];
            2'd1: nibble = display_value[7:4];
            2'd2: nibble = display_value[11:8];
            2'd3: nibble = display_value[15:12];
            default: nibble = 4'h0;
        endcase
    end

    always_comb begin
        seg_next = 7'b1111111;
        case (nibble)
            4'h0: seg_next = 7'b1000000;
            4'h1: seg_next = 7'b1111001;
            4'h2: seg_next = 7'b0100100;
            4'h3: seg_next = 7'b0110000;
            4'h4: seg_next = 7'b0011001;
            4'h5: seg_next = 7'b0010010;
            4'h6: seg_next = 7'b0000010;
            4'h7: seg_next = 7'b1111000;
            4'h8: seg_next = 7'b0000000;
            4'h9: seg_next = 7'b0010000;
            4'hA: seg_next = 7'b0001000;
            4'hB: seg_next = 7'b0000011;
            4'hC: seg_next = 7'b1000110;
            4'hD: seg_next = 7'b0100001;
            4'hE: seg_next = 7'b0000110;
            4'hF: seg_next = 7'b0001110;
            default: seg_next = 7'b1111111;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_anode
            assign anodes_next[gi] = (digit_reg != 2'(gi));
        end
    endgenerate

    assign dp_next = ~((digit_reg == 2'd2) && display_dp);

    always_ff @(posedge clk100Mhz or negedge rst) begin
        if (!rst) begin
            count_reg    <= '0;
            digit_reg    <= 2'd0;
            anodes_reg   <= 4'b1111;
            cathodes_reg <= 7'b1111111;
            dp_reg       <= 1'b1;
        end else begin
            count_reg    <= count_next;
            digit_reg    <= digit_next;
            anodes_reg   <= anodes_next;
            cathodes_reg <= seg_next;
            dp_reg       <= dp_next;
        end
    end

    assign cathodes = cathodes_reg;
    assign anodes   = anodes_reg;
    assign dp       = dp_reg;

endmodule

// File: tb/tb_segment_driver.sv
// ---------------------------------------------------------------------------
// tb_segment_driver
//
// Two instances share the same stimulus. One uses the default dwell of 2500
// clocks. The other uses a dwell of 2 clocks.
//
// The reference model does not follow the RTL. It counts the rising edges
// seen since reset was released. From that count it derives which digit
// should be lit, using the dwell as a divisor. It then looks up the glyph
// for that digit in the hex table.
// ---------------------------------------------------------------------------
module tb_segment_driver;

    localparam int RC      = 2500;
    localparam int RC_FAST = 2;

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk100Mhz = 1'b0;
    logic        rst;
    logic [15:0] display_value;
    logic        display_dp;
    logic [7:1]  cathodes, cathodes_f;
    logic [3:0]  anodes, anodes_f;
    logic        dp, dp_f;

    int n_checks = 0;
    int n_fail   = 0;
    int edges;

    always #5 clk100Mhz = ~clk100Mhz;

    segment_driver dut (
        .clk100Mhz     (clk100Mhz),
        .rst           (rst),
        .display_value (display_value),
        .display_dp    (display_dp),
        .cathodes      (cathodes),
        .anodes        (anodes),
        .dp            (dp)
    );

    segment_driver #(.REFRESH_COUNT(RC_FAST)) dut_fast (
        .clk100Mhz     (clk100Mhz),
        .rst           (rst),
        .display_value (display_value),
        .display_dp    (display_dp),
        .cathodes      (cathodes_f),
        .anodes        (anodes_f),
        .dp            (dp_f)
    );

    // Rising edges seen since reset was last released.
    always @(posedge clk100Mhz or negedge rst) begin
        if (!rst) edges <= 0;
        else      edges <= edges + 1;
    end

    // Expected {anodes, cathodes, dp} for a given dwell length.
    function automatic logic [11:0] model(int rc);
        int         d;
        logic [3:0] an;
        logic [3:0] nib;
        logic       dpo;
        if (!rst || edges == 0) return {4'b1111, 7'b1111111, 1'b1};
        d      = ((edges - 1) / rc) % 4;
        an     = 4'b1111;
        an[d]  = 1'b0;
        nib    = 4'((display_value >> (4 * d)) & 16'hF);
        dpo    = (d == 2 && display_dp) ? 1'b0 : 1'b1;
        return {an, SEG[nib], dpo};
    endfunction

    function automatic int cur_digit(int rc);
        if (edges == 0) return -1;
        return ((edges - 1) / rc) % 4;
    endfunction

    task automatic test_reset();
        logic [11:0] got, exp;
        rst = 1'b0; display_value = 16'h0000; display_dp = 1'b0;
        #20;
        got = {anodes, cathodes, dp};
        n_checks++;
        if (got !== {4'b1111, 7'b1111111, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_blank: got %b expected %b", got, {4'b1111, 7'b1111111, 1'b1});
        end
        got = {anodes_f, cathodes_f, dp_f};
        n_checks++;
        if (got !== {4'b1111, 7'b1111111, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_blank_fast: got %b expected %b", got, {4'b1111, 7'b1111111, 1'b1});
        end
        @(negedge clk100Mhz); rst = 1'b1;
        @(posedge clk100Mhz); #1;
        got = {anodes, cathodes, dp};
        n_checks++;
        if (got !== {4'b1110, 7'b1000000, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_first_edge: got %b expected %b", got, {4'b1110, 7'b1000000, 1'b1});
        end
        exp = model(RC_FAST);
        got = {anodes_f, cathodes_f, dp_f};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_first_edge_fast: got %b expected %b", got, exp);
        end
    endtask

    task automatic test_scan_1234();
        logic [11:0] got, exp;
        display_value = 16'h1234; display_dp = 1'b1;
        repeat (10000) begin
            @(posedge clk100Mhz); #1;
            exp = model(RC);
            got = {anodes, cathodes, dp};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL scan_1234 t=%0t: got %b expected %b", $time, got, exp);
            end
        end
    endtask

    task automatic test_scan_5678();
        logic [11:0] got, exp;
        display_value = 16'h5678; display_dp = 1'b0;
        repeat (10000) begin
            @(posedge clk100Mhz); #1;
            exp = model(RC);
            got = {anodes, cathodes, dp};
            n_checks++;
            if (got !== exp || dp !== 1'b1) begin
                n_fail++;
                $display("FAIL scan_5678 t=%0t: got %b expected %b", $time, got, exp);
            end
        end
    endtask

    task automatic test_uniform_digits();
        logic [11:0] got, exp;
        logic [6:0]  glyph;
        for (int pass = 0; pass < 2; pass++) begin
            display_value = (pass == 0) ? 16'h9999 : 16'h0000;
            display_dp    = 1'b0;
            glyph         = (pass == 0) ? 7'b0010000 : 7'b1000000;
            repeat (10000) begin
                @(posedge clk100Mhz); #1;
                exp = model(RC);
                got = {anodes, cathodes, dp};
                n_checks++;
                if (got !== exp || cathodes !== glyph) begin
                    n_fail++;
                    $display("FAIL uniform_%0d t=%0t: got %b expected %b", pass, $time, got, exp);
                end
            end
        end
    endtask

    // Inputs change at random points, including in the middle of a digit's
    // dwell. Each change must show up at the next edge, and the anode must
    // not move because of it.
    task automatic test_back_to_back();
        logic [11:0] got, exp;
        repeat (3000) begin
            @(posedge clk100Mhz); #1;
            exp = model(RC);
            got = {anodes, cathodes, dp};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL back_to_back t=%0t: got %b expected %b", $time, got, exp);
            end
            if ($urandom_range(3) == 0) begin
                display_value = 16'($urandom);
                display_dp    = 1'($urandom);
            end
        end
    endtask

    task automatic test_reset_midscan();
        logic [11:0] got, exp;
        int          guard;
        display_value = 16'hA5C3; display_dp = 1'b1;
        guard = 0;
        while (cur_digit(RC) != 2 && guard < 12000) begin
            @(posedge clk100Mhz); #1;
            guard++;
        end
        n_checks++;
        if (guard >= 12000) begin
            n_fail++;
            $display("FAIL midscan_wait: digit 2 not reached, got %0d required 2", cur_digit(RC));
        end
        repeat (100) begin
            @(posedge clk100Mhz); #1;
        end
        #3 rst = 1'b0;
        #1;
        got = {anodes, cathodes, dp};
        n_checks++;
        if (got !== {4'b1111, 7'b1111111, 1'b1}) begin
            n_fail++;
            $display("FAIL midscan_async_clear: got %b expected %b", got, {4'b1111, 7'b1111111, 1'b1});
        end
        #18;
        got = {anodes, cathodes, dp};
        n_checks++;
        if (got !== {4'b1111, 7'b1111111, 1'b1}) begin
            n_fail++;
            $display("FAIL midscan_held_blank: got %b expected %b", got, {4'b1111, 7'b1111111, 1'b1});
        end
        #1 rst = 1'b1;
        repeat (3000) begin
            @(posedge clk100Mhz); #1;
            exp = model(RC);
            got = {anodes, cathodes, dp};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL midscan_restart t=%0t: got %b expected %b", $time, got, exp);
            end
        end
    endtask

    task automatic test_fast_hex();
        logic [11:0] got, exp;
        for (int n = 10; n < 16; n++) begin
            display_value = {4{4'(n)}};
            display_dp    = 1'($urandom);
            repeat (16) begin
                @(posedge clk100Mhz); #1;
                exp = model(RC_FAST);
                got = {anodes_f, cathodes_f, dp_f};
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL fast_hex_%h t=%0t: got %b expected %b", n, $time, got, exp);
                end
            end
        end
        repeat (200) begin
            display_value = 16'($urandom);
            display_dp    = 1'($urandom);
            @(posedge clk100Mhz); #1;
            exp = model(RC_FAST);
            got = {anodes_f, cathodes_f, dp_f};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL fast_random t=%0t: got %b expected %b", $time, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_scan_5678();
        test_uniform_digits();
        test_back_to_back();
        test_reset_midscan();
        test_fast_hex();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
